// File: rtl/mux_scan_sequencer_pkg.sv
// Shared constants for the mux scan sequencer: default widths, FSM states,
// settle counter width.
package mux_scan_sequencer_pkg;

  localparam int NCH_DEF    = 8;
  localparam int SEL_W_DEF  = 3;
  localparam int DATA_W_DEF = 4;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/mux_scan_sequencer_rr.sv
// Combinational wrap-around priority finder: first enabled channel at or
// after the pointer, plus mask-nonzero and highest-enabled-channel flags.
module rr_next_channel
  import mux_scan_sequencer_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [NCH-1:0]   i_chan_mask,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [SEL_W-1:0] o_next_ch,
  output logic             o_any,
  output logic [SEL_W-1:0] o_top_ch
);

  logic             w_found;
  logic [SEL_W-1:0] w_idx;

  // NCH is a power of two, so the SEL_W-bit add wraps 7 -> 0 on its own.
  always_comb begin
    o_next_ch = i_ptr;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int k = 0; k < NCH; k++) begin
      w_idx = i_ptr + SEL_W'(k);
      if (!w_found && i_chan_mask[w_idx]) begin
        o_next_ch = w_idx;
        w_found   = 1'b1;
      end
    end
  end

  always_comb begin
    o_top_ch = '0;
    for (int i = 0; i < NCH; i++) begin
      if (i_chan_mask[i]) o_top_ch = SEL_W'(i);
    end
  end

  assign o_any = |i_chan_mask;

endmodule

// File: rtl/mux_scan_sequencer.sv
// Round-robin scan of an 8:1 mux: drive sel, wait SETTLE_CYC cycles, capture
// the mux output and present it on a valid/ready port.
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NCH        = NCH_DEF,
  parameter int SEL_W      = SEL_W_DEF,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NCH-1:0]    chan_mask,
  input  logic [DATA_W-1:0] mux_in,
  output logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_chan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_done,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

  state_t            r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_sel, w_sel_nxt;
  logic [SEL_W-1:0]  r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic [SEL_W-1:0]  r_chan, w_chan_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_fd, w_fd_nxt;

  logic [SEL_W-1:0]  w_next_ch;
  logic              w_any;
  logic [SEL_W-1:0]  w_top_ch;

  rr_next_channel #(
    .NCH   (NCH),
    .SEL_W (SEL_W)
  ) u_rr (
    .i_chan_mask (chan_mask),
    .i_ptr       (r_ptr),
    .o_next_ch   (w_next_ch),
    .o_any       (w_any),
    .o_top_ch    (w_top_ch)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_chan  <= '0;
      r_valid <= 1'b0;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_chan  <= w_chan_nxt;
      r_valid <= w_valid_nxt;
      r_fd    <= w_fd_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_chan_nxt  = r_chan;
    w_valid_nxt = r_valid;
    w_fd_nxt    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (en && w_any) begin
          w_sel_nxt   = w_next_ch;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_data_nxt  = mux_in;
          w_chan_nxt  = r_sel;
          w_valid_nxt = 1'b1;
          w_ptr_nxt   = r_sel + SEL_W'(1);
          w_fd_nxt    = w_any && (r_sel == w_top_ch);
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Handshake edge doubles as the next choice point: no idle bubble.
        if (out_ready) begin
          w_valid_nxt = 1'b0;
          if (en && w_any) begin
            w_sel_nxt   = w_next_ch;
            w_cnt_nxt   = CNT_LOAD;
            w_state_nxt = ST_SETTLE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign sel        = r_sel;
  assign out_data   = r_data;
  assign out_chan   = r_chan;
  assign out_valid  = r_valid;
  assign frame_done = r_fd;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Two sequencers (settle 1 and 3) driven in lockstep, checked every cycle
// against a countdown/queue model, plus directed literal scenarios.
module tb_mux_scan_sequencer;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] chan_mask;
  logic       out_ready;
  logic [3:0] noise    [2];
  logic [3:0] mux_in   [2];
  logic [2:0] sel      [2];
  logic [3:0] out_data [2];
  logic [2:0] out_chan [2];
  logic       out_valid[2];
  logic       frame_done[2];
  logic       busy     [2];

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 0;

  function automatic logic [3:0] tbl(input logic [2:0] s);
    case (s)
      3'd0: return 4'd15;
      3'd1: return 4'd12;
      3'd2: return 4'd10;
      3'd3: return 4'd9;
      3'd4: return 4'd5;
      3'd5: return 4'd2;
      3'd6: return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mux_scan_sequencer #(.SETTLE_CYC(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .rst(rst), .en(en), .chan_mask(chan_mask),
      .mux_in(mux_in[g]), .sel(sel[g]), .out_data(out_data[g]),
      .out_chan(out_chan[g]), .out_valid(out_valid[g]), .out_ready(out_ready),
      .frame_done(frame_done[g]), .busy(busy[g])
    );
    assign mux_in[g] = tbl(sel[g]) ^ noise[g];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Reference model: a chosen channel is captured exactly SETTLE edges later;
  // a new choice is allowed whenever nothing is pending and the output slot is
  // empty or being accepted.
  logic [2:0] m_sel[2], m_ptr[2], m_chan[2];
  logic [3:0] m_data[2];
  bit         m_valid[2], m_fd[2], m_act[2];
  int         m_left[2];

  function automatic logic [2:0] first_from(input logic [7:0] m, input logic [2:0] p);
    for (int k = 0; k < 8; k++)
      if (m[(int'(p) + k) % 8]) return 3'((int'(p) + k) % 8);
    return p;
  endfunction

  function automatic int highest(input logic [7:0] m);
    for (int i = 7; i >= 0; i--) if (m[i]) return i;
    return -1;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_sel[k] = 0; m_ptr[k] = 0; m_chan[k] = 0; m_data[k] = 0;
      m_valid[k] = 0; m_fd[k] = 0; m_act[k] = 0; m_left[k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_sel[k] = 0; m_ptr[k] = 0; m_chan[k] = 0; m_data[k] = 0;
        m_valid[k] = 0; m_fd[k] = 0; m_act[k] = 0; m_left[k] = 0;
      end else begin
        m_fd[k] = 0;
        if (m_act[k]) begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            m_data[k]  = tbl(m_sel[k]) ^ noise[k];
            m_chan[k]  = m_sel[k];
            m_valid[k] = 1;
            m_fd[k]    = (int'(m_sel[k]) == highest(chan_mask));
            m_ptr[k]   = 3'((int'(m_sel[k]) + 1) % 8);
            m_act[k]   = 0;
          end
        end else if (!m_valid[k] || out_ready) begin
          m_valid[k] = 0;
          if (en && chan_mask != 8'h00) begin
            m_sel[k]  = first_from(chan_mask, m_ptr[k]);
            m_act[k]  = 1;
            m_left[k] = (k == 0) ? 1 : 3;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("sel[%0d]", k), int'(sel[k]), int'(m_sel[k]));
        check($sformatf("out_valid[%0d]", k), int'(out_valid[k]), int'(m_valid[k]));
        check($sformatf("out_data[%0d]", k), int'(out_data[k]), int'(m_data[k]));
        check($sformatf("out_chan[%0d]", k), int'(out_chan[k]), int'(m_chan[k]));
        check($sformatf("frame_done[%0d]", k), int'(frame_done[k]), int'(m_fd[k]));
        check($sformatf("busy[%0d]", k), int'(busy[k]), int'(m_act[k] || m_valid[k]));
      end
    end
  end

  // Accepted samples from the settle-1 instance, cleared by reset.
  int qc[$];
  int qd[$];
  int fd_cnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      qc.delete(); qd.delete(); fd_cnt = 0;
    end else begin
      if (frame_done[0]) fd_cnt++;
      if (out_valid[0] && out_ready) begin
        qc.push_back(int'(out_chan[0]));
        qd.push_back(int'(out_data[0]));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_q(input int n, input string nm);
    int t = 0;
    while (qc.size() < n && t < 200) begin
      @(negedge clk); t++;
    end
    check(nm, qc.size() >= n ? n : qc.size(), n);
  endtask

  task automatic wait_valid0(input string nm);
    int t = 0;
    while (!out_valid[0] && t < 50) begin
      @(negedge clk); t++;
    end
    check(nm, int'(out_valid[0]), 1);
  endtask

  function automatic int qget_c(input int i);
    return (i < qc.size()) ? qc[i] : -1;
  endfunction
  function automatic int qget_d(input int i);
    return (i < qd.size()) ? qd[i] : -1;
  endfunction

  int ea_c[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
  int ea_d[9] = '{15, 12, 10, 9, 5, 2, 8, 4, 15};
  int eb_c[4] = '{2, 5, 7, 2};
  int eb_d[4] = '{10, 2, 4, 10};

  initial begin
    rst = 1'b1; en = 1'b0; chan_mask = 8'h00; out_ready = 1'b0;
    noise[0] = 4'h0; noise[1] = 4'h0;
    do_reset();
    chk_on = 1;
    check("rst_sel", int'(sel[0]), 0);
    check("rst_valid", int'(out_valid[0]), 0);
    check("rst_busy", int'(busy[0]), 0);
    check("rst_data", int'(out_data[0]), 0);
    check("rst_fd", int'(frame_done[0]), 0);

    // Full scan, two-cycle latency and one sample every two cycles
    chan_mask = 8'hFF; out_ready = 1'b1; en = 1'b1;
    @(negedge clk);
    check("lat_valid_n0", int'(out_valid[0]), 0);
    @(negedge clk);
    check("lat_valid_n1", int'(out_valid[0]), 1);
    check("lat_data_n1", int'(out_data[0]), 15);
    check("model_valid_n1", int'(m_valid[0]), 1);
    check("model_data_n1", int'(m_data[0]), 15);
    wait_q(9, "scan_full_cnt");
    for (int i = 0; i < 9; i++) begin
      check($sformatf("scan_full_ch%0d", i), qget_c(i), ea_c[i]);
      check($sformatf("scan_full_dat%0d", i), qget_d(i), ea_d[i]);
    end
    check("scan_full_fd_cnt", fd_cnt, 1);

    // Sparse mask
    do_reset();
    chan_mask = 8'b1010_0100; out_ready = 1'b1; en = 1'b1;
    wait_q(4, "scan_sparse_cnt");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("scan_sparse_ch%0d", i), qget_c(i), eb_c[i]);
      check($sformatf("scan_sparse_dat%0d", i), qget_d(i), eb_d[i]);
    end
    check("scan_sparse_fd_cnt", fd_cnt, 1);

    // Backpressure
    do_reset();
    chan_mask = 8'hFF; out_ready = 1'b0; en = 1'b1;
    wait_valid0("bp_first_valid");
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", int'(out_valid[0]), 1);
      check("bp_data", int'(out_data[0]), 15);
      check("bp_chan", int'(out_chan[0]), 0);
      check("bp_sel", int'(sel[0]), 0);
    end
    out_ready = 1'b1;
    wait_q(2, "bp_cnt");
    check("bp_ch1", qget_c(1), 1);
    check("bp_dat1", qget_d(1), 12);

    // Empty mask never starts
    do_reset();
    chan_mask = 8'h00; en = 1'b1; out_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("mask0_busy", int'(busy[0]), 0);
      check("mask0_valid", int'(out_valid[0]), 0);
    end

    // Dropping en while holding returns to idle after the handshake
    chan_mask = 8'hFF; out_ready = 1'b0;
    wait_valid0("endrop_valid");
    en = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("endrop_busy", int'(busy[0]), 0);
    check("endrop_valid", int'(out_valid[0]), 0);

    // Reset while settling on channel 3
    do_reset();
    chan_mask = 8'hFF; out_ready = 1'b1; en = 1'b1;
    begin
      int t = 0;
      while (!(sel[0] == 3'd3 && busy[0] && !out_valid[0]) && t < 50) begin
        @(negedge clk); t++;
      end
      check("midrst_reach_ch3", int'(sel[0]), 3);
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sel", int'(sel[0]), 0);
    check("midrst_valid", int'(out_valid[0]), 0);
    check("midrst_busy", int'(busy[0]), 0);
    rst = 1'b0;
    wait_q(1, "midrst_cnt");
    check("midrst_ch0", qget_c(0), 0);
    check("midrst_dat0", qget_d(0), 15);

    // Settle-3 instance: 4-cycle latency, only the capture-edge value counts
    do_reset();
    chan_mask = 8'hFF; out_ready = 1'b1; en = 1'b1;
    @(negedge clk);
    check("s3_valid_n0", int'(out_valid[1]), 0);
    noise[1] = 4'h5;
    @(negedge clk);
    check("s3_valid_n1", int'(out_valid[1]), 0);
    noise[1] = 4'h3;
    @(negedge clk);
    check("s3_valid_n2", int'(out_valid[1]), 0);
    noise[1] = 4'h0;
    @(negedge clk);
    check("s3_valid_n3", int'(out_valid[1]), 1);
    check("s3_data_n3", int'(out_data[1]), 15);
    check("s3_chan_n3", int'(out_chan[1]), 0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      noise[0] = 4'($urandom);
      noise[1] = 4'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0: chan_mask = 8'h00;
          1: chan_mask = 8'(1 << $urandom_range(0, 7));
          default: chan_mask = 8'($urandom);
        endcase
      end
    end
    rst = 1'b0;
    @(negedge clk);
    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream control stage for the 8:1, 4-bit channel multiplexer. It drives the mux `select` input and captures the mux output.
- Scans enabled channels in round-robin order. For each channel it drives `sel`, waits a programmable settle time, then registers the mux output.
- Presents each captured sample with its channel number on a valid/ready output interface.
- Pulses `frame_done` when a full pass over the enabled channels completes.

Parameters:
- DATA_W, 4, width of each mux channel and of `out_data`.
- NCH, 8, number of mux channels; fixed at 8 in this revision.
- SEL_W, 3, select width; must equal clog2(NCH).
- SETTLE_CYC, 1, cycles `sel` is held stable before capture. Legal range 1..15; 0 is illegal.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  scan enable, sampled only when a new channel is chosen.
- chan_mask  input  NCH  per-channel enable; bit i=1 includes channel i in the scan.
- mux_in  input  DATA_W  output of the downstream 8:1 mux.
- sel  output  SEL_W  registered select driven to the mux.
- out_data  output  DATA_W  captured sample.
- out_chan  output  SEL_W  channel number of `out_data`.
- out_valid  output  1  `out_data`/`out_chan` hold a sample not yet accepted.
- out_ready  input  1  consumer accepts the sample when out_valid && out_ready.
- frame_done  output  1  one-cycle pulse when the highest enabled channel is captured.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (rst=1 at a rising edge):
  - sel=0, out_data=0, out_chan=0, out_valid=0, frame_done=0, busy=0.
  - state=IDLE, next-pointer ptr=0.
  - Applies in any state; an in-flight settle or capture is discarded.
- States: IDLE, SETTLE, HOLD.
- Channel choice (next_ch):
  - First set bit of chan_mask at or after ptr, searching upward and wrapping from 7 to 0.
  - Combinational; evaluated only at choice points.
- IDLE:
  - If en=1 and chan_mask!=0: sel<=next_ch, cnt<=SETTLE_CYC-1, go to SETTLE.
  - Otherwise stay in IDLE; sel holds its last value.
- SETTLE:
  - While cnt!=0: cnt<=cnt-1.
  - When cnt==0: out_data<=mux_in, out_chan<=sel, out_valid<=1, ptr<=(sel+1) mod 8, go to HOLD.
  - frame_done<=1 if sel equals the highest set bit of chan_mask at that edge.
- HOLD:
  - Leaves on handshake (out_ready=1): out_valid<=0 at that edge.
  - On that same edge, if en=1 and chan_mask!=0: sel<=next_ch (using the updated ptr), go to SETTLE. Back-to-back scanning, no idle bubble.
  - On that same edge otherwise: go to IDLE.
  - Without handshake: out_data, out_chan and out_valid hold stable; mux_in is ignored.
- frame_done: high for exactly the one cycle after the capture edge; registered.
- Latency:
  - en first high in cycle N (IDLE) → out_valid high from the cycle after edge N+SETTLE_CYC.
  - With SETTLE_CYC=1: 2 cycles from en to valid.
  - Steady-state throughput with out_ready=1: one sample per SETTLE_CYC+1 cycles.
- Boundary rules:
  - Changes to chan_mask or en during SETTLE do not abort; the chosen channel completes.
  - A mask change during HOLD takes effect at the next choice.
  - chan_mask==0 at a choice point → IDLE.
  - Single enabled channel: that channel is re-sampled repeatedly, with frame_done on every capture.
  - ptr wraps 7→0.
  - out_ready while out_valid=0 is ignored.
  - sel changes only at choice edges; it never glitches during SETTLE or HOLD.
- Widths: cnt is 4 bits; ptr is SEL_W bits with modulo wrap. No arithmetic on data.

Decomposition:
- Shared package:
  - NCH, SEL_W, DATA_W defaults.
  - State encoding constants ST_IDLE=2'd0, ST_SETTLE=2'd1, ST_HOLD=2'd2.
  - SETTLE counter width constant.
- One sub-module: rr_next_channel, a combinational wrap-around priority finder.
  - Inputs: chan_mask, ptr.
  - Outputs: next_ch, any (mask non-zero), top_ch (highest set bit).
- The FSM, counter and output registers stay in mux_scan_sequencer.

Test Plan:
- Bench setup: instantiate the 8:1 mux with datain_0..7 = 15,12,10,9,5,2,8,4 and sel driving its select.
- Full scan: mask=8'hFF, en=1, out_ready=1, SETTLE_CYC=1 → (chan,data) = (0,15),(1,12),(2,10),(3,9),(4,5),(5,2),(6,8),(7,4),(0,15), one sample every 2 cycles; frame_done only after chan 7.
- Sparse mask: mask=8'b1010_0100 → sequence (2,10),(5,2),(7,4),(2,10); frame_done after each chan 7.
- Backpressure: out_ready=0 for 5 cycles after the first valid → out_valid, out_data=15 and out_chan=0 stable, sel stays 0. Releasing out_ready yields (1,12) 2 cycles later.
- Idle conditions:
  - mask=0 with en=1 → busy=0, out_valid never asserts.
  - Dropping en while in HOLD with out_ready=1 → return to IDLE after that capture.
- Reset mid-operation: assert rst during SETTLE of chan 3 → next cycle sel=0, out_valid=0, busy=0. After release, the scan restarts at chan 0 (data 15).
- Settle timing: SETTLE_CYC=3 → out_valid rises 4 cycles after en. Changing mux_in during the first 2 SETTLE cycles does not affect captured data; only the value at the capture edge is taken.
